tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
IEEE 1149.1 TAP state machine clocked by TCK and steered by TMS. It drives the capture, shift and update strobes and the gated IR/DR clocks that the instruction register and data registers consume. It also produces the test-logic-reset level, the IR/DR select and the TDO enable.

Parameters:
GATED_CLK, 1, 1: tck_ir/tck_dr are AND-gated TCK; 0: tck_ir/tck_dr equal tck and the enable levels are exported only.

Ports:
tck  input  1  JTAG test clock
tl_reset  input  1  TRST*, asynchronous, active-low
tms  input  1  test mode select, sampled on rising tck
tlr_n  output  1  test-logic-reset level, active-low; feeds IR/DR tl_reset
capture_ir  output  1  high while in Capture-IR
shift_ir  output  1  high while in Shift-IR
update_ir  output  1  update strobe for the IR latch; used as a clock edge downstream
capture_dr  output  1  high while in Capture-DR
shift_dr  output  1  high while in Shift-DR
update_dr  output  1  update strobe for DR latches
tck_ir  output  1  gated clock, active in Capture-IR/Shift-IR
tck_dr  output  1  gated clock, active in Capture-DR/Shift-DR
select  output  1  1 = IR path to TDO, 0 = DR path
tdo_enable  output  1  TDO driver enable
run_test_idle  output  1  high while in Run-Test/Idle

Behaviour:
- Reset: tl_reset is asynchronous, active-low. While it is low:
  - state = TEST_LOGIC_RESET.
  - tlr_n = 0.
  - All strobes, select, tdo_enable and the clock-gate enables = 0.
  - run_test_idle = 0.
  - Deassertion of tl_reset is synchronised to tck; the FSM leaves TLR only on a rising tck with tms=0.
- State register: updates on rising tck. Encoding is fixed (hex): TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAUSE_DR 3, EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAUSE_IR B, EX2_IR 8, UPD_IR D.
- Transitions, written as state: tms=0 -> / tms=1 ->:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PAUSE_DR / UPD_DR
  - PAUSE_DR: PAUSE_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR column mirrors the DR column; UPD_IR: RTI / SEL_DR
- Five consecutive rising tck with tms=1 reach TLR from any state.
- Output registers: all outputs are registered on falling tck from the current state, so each is stable across the following rising edge.
  - capture_* and shift_*: high from the falling edge inside the corresponding state until the falling edge after leaving it.
  - update_ir / update_dr: rising edge occurs at the falling tck inside UPD_IR / UPD_DR; the pulse lasts exactly one tck period; glitch-free.
  - tlr_n: 0 from the falling edge inside TLR; 1 from the falling edge inside RTI.
  - select: 1 in SEL_IR through UPD_IR, 0 elsewhere. The Select-IR step fixes this to SEL_IR..UPD_IR, not CAP_IR..UPD_IR.
  - tdo_enable: 1 in SH_IR and SH_DR only.
  - run_test_idle: 1 in RTI.
- Gated clocks (GATED_CLK=1):
  - tck_ir = tck AND en_ir. en_ir is set at the falling edge inside CAP_IR or SH_IR.
  - Result: one pulse per rising tck whose pre-edge state is CAP_IR or SH_IR.
  - tck_dr is the same, using CAP_DR/SH_DR.
  - Enables change only while tck is low, so no glitches.
- Simultaneous events: an asynchronous reset during Update-xR truncates the update pulse to 0 immediately and produces no extra edge. tms is don't-care while tl_reset is low.

Optional Feature:
TAP_STATE_OUT_EN.
- Defined: adds output port tap_state [3:0], the registered state using the encoding above, for debug/ILA.
- Undefined: the port is absent and behaviour is unchanged.

Decomposition:
- Package tap_pkg:
  - tap_state_e enum with the fixed encoding above.
  - TAP_STATE_W = 4.
  - A localparam for the TLR entry count (5).
- Sub-module tap_clk_gate: negedge enable register plus AND, instantiated twice (IR, DR). It becomes a passthrough when GATED_CLK=0.

Test Plan:
- Reset plus TMS walk: assert tl_reset=0 mid-Shift-DR -> state F, tlr_n=0, tck_dr silent. Release, then tms=0 -> state C and tlr_n=1 at the next falling tck.
- IR load: from RTI apply tms 1,1,0,0, then shift 4 bits with tms 0,0,0,1, then 1,0 -> exactly 1 capture plus 4 shift pulses on tck_ir. capture_ir is high for the first edge only. update_ir rises once, at the falling edge inside state D. select=1 throughout.
- DR scan with pause: tms 1,0,0,0,1,0,0,1,0,1,1 -> tck_dr pulses only in CAP_DR/SH_DR, none in PAUSE_DR. update_dr rises exactly once. tdo_enable=0 during PAUSE_DR.
- Five-ones reset: from each of the 16 states, drive tms=1 for 5 tck -> state F and tlr_n=0. From SEL_IR, a single tms=1 gives TLR.
- Glitch check: a bench monitor asserts that tck_ir/tck_dr/update_* never have pulses shorter than half a tck period across a randomised 10k-cycle tms run. Every transition is checked against a reference model.
- TAP_STATE_OUT_EN build: tap_state tracks the model every cycle. Compiling without the macro leaves all other outputs unchanged.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: fixed IEEE 1149.1 state encoding, registered output bundle
// and the next-state function used by the controller.
package tap_pkg;

  localparam int TAP_STATE_W     = 4;
  localparam int TLR_ENTRY_COUNT = 5;  // consecutive tms=1 edges that reach TLR from anywhere

  typedef enum logic [TAP_STATE_W-1:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic tlr_n;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic select;
    logic tdo_enable;
    logic run_test_idle;
  } tap_out_t;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:      n = tms ? TLR    : RTI;
      RTI:      n = tms ? SEL_DR : RTI;
      SEL_DR:   n = tms ? SEL_IR : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR : SH_DR;
      SH_DR:    n = tms ? EX1_DR : SH_DR;
      EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR : SH_DR;
      UPD_DR:   n = tms ? SEL_DR : RTI;
      SEL_IR:   n = tms ? TLR    : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR : SH_IR;
      SH_IR:    n = tms ? EX1_IR : SH_IR;
      EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR : SH_IR;
      UPD_IR:   n = tms ? SEL_DR : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_clk_gate.sv
// Glitch-free clock gate: enable captured on falling tck, ANDed with tck.
// With GATED_CLK=0 the output is tck itself.
module tap_clk_gate #(
  parameter bit GATED_CLK = 1'b1
) (
  input  logic tck,
  input  logic tl_reset,
  input  logic en,
  output logic gclk
);

  generate
    if (GATED_CLK) begin : g_gate
      logic en_reg;

      // Enable only moves while tck is low, so the AND cannot chop a high phase.
      always_ff @(negedge tck or negedge tl_reset) begin
        if (!tl_reset) en_reg <= 1'b0;
        else           en_reg <= en;
      end

      assign gclk = tck & en_reg;
    end else begin : g_pass
      assign gclk = tck;
    end
  endgenerate

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with falling-edge registered strobes and gated IR/DR clocks.
// Optional debug port tap_state is added when TAP_STATE_OUT_EN is defined.
module tap_controller
  import tap_pkg::*;
#(
  parameter bit GATED_CLK = 1'b1
) (
  input  logic tck,
  input  logic tl_reset,
  input  logic tms,
  output logic tlr_n,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic tck_ir,
  output logic tck_dr,
  output logic select,
  output logic tdo_enable,
  output logic run_test_idle
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [TAP_STATE_W-1:0] tap_state
`endif
);

  tap_state_e state_reg;
  tap_state_e state_next;
  tap_out_t   out_next;
  tap_out_t   out_reg;
  logic [1:0] gate_en_next;  // [0] IR, [1] DR
  logic [1:0] gated_tck;

  always_ff @(posedge tck or negedge tl_reset) begin
    if (!tl_reset) state_reg <= TLR;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = tap_next(state_reg, tms);
  end

  always_comb begin
    out_next      = '0;
    gate_en_next  = '0;
    out_next.tlr_n         = (state_reg != TLR);
    out_next.run_test_idle = (state_reg == RTI);
    out_next.select        = (state_reg inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                                                PAUSE_IR, EX2_IR, UPD_IR});
    case (state_reg)
      CAP_IR: begin
        out_next.capture_ir = 1'b1;
        gate_en_next[0]     = 1'b1;
      end
      SH_IR: begin
        out_next.shift_ir   = 1'b1;
        out_next.tdo_enable = 1'b1;
        gate_en_next[0]     = 1'b1;
      end
      UPD_IR: out_next.update_ir = 1'b1;
      CAP_DR: begin
        out_next.capture_dr = 1'b1;
        gate_en_next[1]     = 1'b1;
      end
      SH_DR: begin
        out_next.shift_dr   = 1'b1;
        out_next.tdo_enable = 1'b1;
        gate_en_next[1]     = 1'b1;
      end
      UPD_DR: out_next.update_dr = 1'b1;
      default: ;
    endcase
  end

  // Falling-edge outputs stay stable across the rising edge that consumes them;
  // the async clear also truncates an update pulse without creating a new edge.
  always_ff @(negedge tck or negedge tl_reset) begin
    if (!tl_reset) out_reg <= '0;
    else           out_reg <= out_next;
  end

  assign tlr_n         = out_reg.tlr_n;
  assign capture_ir    = out_reg.capture_ir;
  assign shift_ir      = out_reg.shift_ir;
  assign update_ir     = out_reg.update_ir;
  assign capture_dr    = out_reg.capture_dr;
  assign shift_dr      = out_reg.shift_dr;
  assign update_dr     = out_reg.update_dr;
  assign select        = out_reg.select;
  assign tdo_enable    = out_reg.tdo_enable;
  assign run_test_idle = out_reg.run_test_idle;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_clk_gate
      tap_clk_gate #(
        .GATED_CLK (GATED_CLK)
      ) u_gate (
        .tck      (tck),
        .tl_reset (tl_reset),
        .en       (gate_en_next[gi]),
        .gclk     (gated_tck[gi])
      );
    end
  endgenerate

  assign tck_ir = gated_tck[0];
  assign tck_dr = gated_tck[1];

`ifdef TAP_STATE_OUT_EN
  assign tap_state = state_reg;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed + random TMS bench for tap_controller with an independent state model,
// gated-clock pulse counters and a pulse-width monitor.
module tb_tap_controller;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6,
                         S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PAUSE_DR = 4'h3, S_EX2_DR = 4'h0,
                         S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA,
                         S_EX1_IR = 4'h9, S_PAUSE_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;
  localparam int HALF = 5;

  logic tck = 1'b0;
  logic tl_reset = 1'b0;
  logic tms = 1'b1;
  logic tlr_n, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
  logic tck_ir, tck_dr, select, tdo_enable, run_test_idle;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] tap_state;
`endif

  tap_controller #(.GATED_CLK(1'b1)) dut (
    .tck           (tck),
    .tl_reset      (tl_reset),
    .tms           (tms),
    .tlr_n         (tlr_n),
    .capture_ir    (capture_ir),
    .shift_ir      (shift_ir),
    .update_ir     (update_ir),
    .capture_dr    (capture_dr),
    .shift_dr      (shift_dr),
    .update_dr     (update_dr),
    .tck_ir        (tck_ir),
    .tck_dr        (tck_dr),
    .select        (select),
    .tdo_enable    (tdo_enable),
    .run_test_idle (run_test_idle)
`ifdef TAP_STATE_OUT_EN
    ,
    .tap_state     (tap_state)
`endif
  );

  always #HALF tck = ~tck;

  int checks = 0;
  int failures = 0;
  int ir_pulses = 0, dr_pulses = 0, uir_rises = 0, udr_rises = 0;
  int exp_ir = 0, exp_dr = 0, exp_uir = 0, exp_udr = 0;
  logic [3:0] model_st = S_TLR;
  logic [9:0] outs_vec;
  logic [3:0] mon;
  logic [6:0] path_bits [16];
  int path_len [16];

  assign outs_vec = {tlr_n, capture_ir, shift_ir, update_ir, capture_dr, shift_dr,
                     update_dr, select, tdo_enable, run_test_idle};
  assign mon = {update_dr, update_ir, tck_dr, tck_ir};

  always @(posedge tck_ir)    ir_pulses++;
  always @(posedge tck_dr)    dr_pulses++;
  always @(posedge update_ir) uir_rises++;
  always @(posedge update_dr) udr_rises++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse-width monitor; a pulse cut short by async reset is legal and skipped.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mon
    longint t_rise = 0;
    bit seen = 1'b0;
    always @(posedge mon[gi]) begin
      t_rise = $time;
      seen = 1'b1;
    end
    always @(negedge mon[gi]) begin
      if (seen && tl_reset)
        check_eq($sformatf("pulse_width_%0d", gi), 32'(($time - t_rise) >= HALF), 32'd1);
    end
  end

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
    case (s)
      S_TLR:      return t ? S_TLR    : S_RTI;
      S_RTI:      return t ? S_SEL_DR : S_RTI;
      S_SEL_DR:   return t ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   return t ? S_EX1_DR : S_SH_DR;
      S_SH_DR:    return t ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:   return t ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: return t ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   return t ? S_UPD_DR : S_SH_DR;
      S_UPD_DR:   return t ? S_SEL_DR : S_RTI;
      S_SEL_IR:   return t ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   return t ? S_EX1_IR : S_SH_IR;
      S_SH_IR:    return t ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:   return t ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: return t ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   return t ? S_UPD_IR : S_SH_IR;
      default:    return t ? S_SEL_DR : S_RTI;  // S_UPD_IR
    endcase
  endfunction

  function automatic logic [9:0] model_outs(input logic [3:0] s);
    logic ir_col;
    ir_col = (s == S_SEL_IR) || (s == S_CAP_IR) || (s == S_SH_IR) || (s == S_EX1_IR) ||
             (s == S_PAUSE_IR) || (s == S_EX2_IR) || (s == S_UPD_IR);
    return {s != S_TLR, s == S_CAP_IR, s == S_SH_IR, s == S_UPD_IR, s == S_CAP_DR,
            s == S_SH_DR, s == S_UPD_DR, ir_col, (s == S_SH_IR) || (s == S_SH_DR),
            s == S_RTI};
  endfunction

  // One tck period: drive tms while low, advance model at rising edge, check after falling edge.
  task automatic step(input logic t, input bit verbose);
    logic [3:0] pre;
    tms = t;
    @(posedge tck);
    pre = model_st;
    if (!tl_reset) model_st = S_TLR;
    else           model_st = model_next(model_st, t);
    if (tl_reset && (pre == S_CAP_IR || pre == S_SH_IR)) exp_ir++;
    if (tl_reset && (pre == S_CAP_DR || pre == S_SH_DR)) exp_dr++;
    @(negedge tck);
    #1;
    if (tl_reset && model_st == S_UPD_IR) exp_uir++;
    if (tl_reset && model_st == S_UPD_DR) exp_udr++;
    check_eq($sformatf("outs_in_%h", model_st), 32'(outs_vec), 32'(model_outs(model_st)));
    check_eq("tck_ir_pulses", ir_pulses, exp_ir);
    check_eq("tck_dr_pulses", dr_pulses, exp_dr);
    check_eq("update_ir_rises", uir_rises, exp_uir);
    check_eq("update_dr_rises", udr_rises, exp_udr);
`ifdef TAP_STATE_OUT_EN
    check_eq("tap_state", 32'(tap_state), 32'(model_st));
`endif
    if (verbose)
      $display("step tms=%b rst_n=%b state %h -> %h outs=%b", t, tl_reset, pre, model_st, outs_vec);
  endtask

  task automatic apply_seq(input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) step(bits[i], 1'b1);
  endtask

  // Called with tck low, just after a falling edge.
  task automatic async_reset(input string tag);
    tl_reset = 1'b0;
    #1;
    model_st = S_TLR;
    check_eq({tag, "_outs"}, 32'(outs_vec), 32'd0);
    check_eq({tag, "_tck_dr"}, 32'(tck_dr), 32'd0);
    $display("async reset asserted (%s)", tag);
  endtask

  int snap_ir, snap_dr, snap_uir, snap_udr;
  task automatic snapshot();
    snap_ir = ir_pulses; snap_dr = dr_pulses; snap_uir = uir_rises; snap_udr = udr_rises;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    path_len[4'hF] = 0; path_bits[4'hF] = 7'b0000000;
    path_len[4'hC] = 1; path_bits[4'hC] = 7'b0000000;
    path_len[4'h7] = 2; path_bits[4'h7] = 7'b0000010;
    path_len[4'h6] = 3; path_bits[4'h6] = 7'b0000010;
    path_len[4'h2] = 4; path_bits[4'h2] = 7'b0000010;
    path_len[4'h1] = 4; path_bits[4'h1] = 7'b0001010;
    path_len[4'h3] = 5; path_bits[4'h3] = 7'b0001010;
    path_len[4'h0] = 6; path_bits[4'h0] = 7'b0101010;
    path_len[4'h5] = 5; path_bits[4'h5] = 7'b0011010;
    path_len[4'h4] = 3; path_bits[4'h4] = 7'b0000110;
    path_len[4'hE] = 4; path_bits[4'hE] = 7'b0000110;
    path_len[4'hA] = 5; path_bits[4'hA] = 7'b0000110;
    path_len[4'h9] = 5; path_bits[4'h9] = 7'b0010110;
    path_len[4'hB] = 6; path_bits[4'hB] = 7'b0010110;
    path_len[4'h8] = 7; path_bits[4'h8] = 7'b1010110;
    path_len[4'hD] = 6; path_bits[4'hD] = 7'b0110110;

    // Reset state
    repeat (2) @(negedge tck);
    #1;
    check_eq("reset_outs", 32'(outs_vec), 32'd0);
    check_eq("reset_tck_ir", 32'(tck_ir), 32'd0);
    check_eq("reset_tck_dr_pulses", dr_pulses, 0);
    step(1'b0, 1'b1);  // tms=0 under reset must not leave TLR
    tl_reset = 1'b1;
    step(1'b0, 1'b1);
    check_eq("release_tlr_n", 32'(tlr_n), 32'd1);
    check_eq("release_rti", 32'(run_test_idle), 32'd1);

    // Reset asserted mid Shift-DR
    apply_seq(16'b0000, 4);  // RTI stays RTI
    apply_seq(16'b000_1, 4); // SEL_DR, CAP_DR, SH_DR, SH_DR
    check_eq("in_shift_dr", 32'(shift_dr), 32'd1);
    snapshot();
    async_reset("rst_in_shdr");
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_eq("rst_tck_dr_silent", dr_pulses - snap_dr, 0);
    tl_reset = 1'b1;
    step(1'b0, 1'b1);
    check_eq("rst_release_tlr_n", 32'(tlr_n), 32'd1);

    // IR load: 1,1,0,0 then 0,0,0,1 then 1,0 (bit0 applied first)
    $display("IR load sequence");
    snapshot();
    apply_seq(16'b01_1000_0011, 10);
    check_eq("ir_load_tck_ir", ir_pulses - snap_ir, 5);
    check_eq("ir_load_tck_dr", dr_pulses - snap_dr, 0);
    check_eq("ir_load_update_ir", uir_rises - snap_uir, 1);

    // DR scan with pause: 1,0,0,0,1,0,0,1,0,1,1 ends in UPD_DR
    $display("DR scan with pause");
    snapshot();
    apply_seq(16'b110_1001_0001, 11);
    check_eq("dr_scan_tck_dr", dr_pulses - snap_dr, 4);
    check_eq("dr_scan_tck_ir", ir_pulses - snap_ir, 0);
    check_eq("dr_scan_update_dr", udr_rises - snap_udr, 1);

    // Async reset while update_dr is high truncates it
    check_eq("upd_dr_high", 32'(update_dr), 32'd1);
    async_reset("rst_in_upddr");
    check_eq("upd_dr_truncated", 32'(update_dr), 32'd0);
    step(1'b1, 1'b1);
    tl_reset = 1'b1;
    step(1'b0, 1'b1);

    // Five ones from every state
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < tap_pkg::TLR_ENTRY_COUNT; k++) step(1'b1, 1'b0);
      for (int i = 0; i < path_len[s]; i++) step(path_bits[s][i], 1'b0);
      for (int k = 0; k < tap_pkg::TLR_ENTRY_COUNT; k++) step(1'b1, 1'b0);
      check_eq($sformatf("five_ones_from_%h", s), 32'(tlr_n), 32'd0);
      $display("five ones from state %h -> tlr_n=%b", s, tlr_n);
    end

    // Select-IR: a single tms=1 goes to TLR
    apply_seq(16'b110, 3);
    check_eq("sel_ir_select", 32'(select), 32'd1);
    step(1'b1, 1'b1);
    check_eq("sel_ir_to_tlr", 32'(tlr_n), 32'd0);

    // Random TMS walk
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), 1'b0);
      $display("random block %0d done, state %h, checks=%0d", blk, model_st, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
